// File: rtl/trng_sched_pkg.sv
// Shared types for the TRNG scheduler; the AXI wrapper imports this package
// to decode the state code reported on the status port.
package trng_sched_pkg;

  localparam int TRNG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_TRIG    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FAULT   = 3'd5
  } trng_state_e;

endpackage

// File: rtl/trng_fifo.sv
// Entropy word FIFO: synchronous push/pop/flush with a combinational head.
// Flush wins over a same-cycle push or pop.
module trng_fifo
  import trng_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [TRNG_WORD_W-1:0]     data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [TRNG_WORD_W-1:0]     head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [TRNG_WORD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            level_q, level_d;
  logic                   do_push, do_pop;

  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trng_sched.sv
// TRNG sampler sequencer: warm-up, periodic triggers, capture into a FIFO shared
// by two round-robin consumers. Define TRNG_HEALTH_EN for the repetition check.
module trng_sched
  import trng_sched_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int WARMUP_CYCLES   = 1024,
  parameter int SAMPLE_INTERVAL = 64,
  parameter int CAPTURE_DELAY   = 2,
  parameter int REP_LIMIT       = 4
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        cfg_enable,
  input  logic                        cfg_flush,
  input  logic                        trng_osc_running,
  input  logic [TRNG_WORD_W-1:0]      trng_random,
  output logic                        trng_enable,
  output logic                        trng_sample_trig,
  output logic                        trng_clear,
  input  logic                        c0_req,
  input  logic                        c1_req,
  output logic                        c0_ack,
  output logic                        c1_ack,
  output logic [TRNG_WORD_W-1:0]      rnd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [2:0]                  state,
  output logic                        health_fail
);

  localparam int WARM_W = $clog2(WARMUP_CYCLES) + 1;
  localparam int INT_W  = $clog2(SAMPLE_INTERVAL) + 1;
  localparam int CAP_W  = $clog2(CAPTURE_DELAY) + 1;

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [INT_W-1:0]  INT_LAST  = INT_W'(SAMPLE_INTERVAL - 1);
  localparam logic [CAP_W-1:0]  CAP_LAST  = CAP_W'(CAPTURE_DELAY - 1);

  trng_state_e          state_q, state_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [INT_W-1:0]     int_cnt_q, int_cnt_d;
  logic [CAP_W-1:0]     cap_cnt_q, cap_cnt_d;
  logic                 enable_q, enable_d;
  logic                 trig_q, trig_d;
  logic                 clear_q, clear_d;
  logic                 rr_q, rr_d;
  logic                 push_w;
  logic                 fault_enter;
  logic                 flush_all;
  logic                 health_trip;
  logic                 arb_ok;
  logic                 fifo_full, fifo_empty;
  logic [TRNG_WORD_W-1:0] fifo_head;

  // Next-state and counter logic; a dropped enable overrides everything.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    int_cnt_d  = int_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    push_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        warm_cnt_d = '0;
        if (cfg_enable) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          if (trng_osc_running) begin
            state_d   = ST_WAIT;
            int_cnt_d = '0;
          end
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (int_cnt_q == INT_LAST) begin
          if (!fifo_full) state_d = ST_TRIG;
        end else begin
          int_cnt_d = int_cnt_q + 1'b1;
        end
      end
      ST_TRIG: begin
        state_d   = ST_CAPTURE;
        cap_cnt_d = '0;
      end
      ST_CAPTURE: begin
        if (cap_cnt_q == CAP_LAST) begin
          if (health_trip) begin
            state_d = ST_FAULT;
          end else begin
            push_w    = 1'b1;
            state_d   = ST_WAIT;
            int_cnt_d = '0;
          end
        end else begin
          cap_cnt_d = cap_cnt_q + 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    if (!cfg_enable) begin
      state_d = ST_IDLE;
      push_w  = 1'b0;
    end
  end

  assign fault_enter = (state_d == ST_FAULT) && (state_q != ST_FAULT);
  assign flush_all   = cfg_flush || fault_enter;

  // Sampler controls are registered decodes of the next state.
  always_comb begin
    enable_d = (state_d == ST_WARMUP) || (state_d == ST_WAIT) ||
               (state_d == ST_TRIG)   || (state_d == ST_CAPTURE);
    trig_d   = (state_d == ST_TRIG);
    clear_d  = (state_q == ST_IDLE) && (state_d == ST_WARMUP);
  end

  // Round-robin: rr_q high means c1 has priority on a tie.
  always_comb begin
    arb_ok   = !fifo_empty && !flush_all;
    c0_ack   = arb_ok && c0_req && (!c1_req || !rr_q);
    c1_ack   = arb_ok && c1_req && (!c0_req || rr_q);
    rnd_data = (c0_ack || c1_ack) ? fifo_head : '0;
    rr_d     = rr_q;
    if (c0_ack)      rr_d = 1'b1;
    else if (c1_ack) rr_d = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      warm_cnt_q <= '0;
      int_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      enable_q   <= 1'b0;
      trig_q     <= 1'b0;
      clear_q    <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      int_cnt_q  <= int_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      enable_q   <= enable_d;
      trig_q     <= trig_d;
      clear_q    <= clear_d;
      rr_q       <= rr_d;
    end
  end

  assign trng_enable      = enable_q;
  assign trng_sample_trig = trig_q;
  assign trng_clear       = clear_q;
  assign state            = state_q;

`ifdef TRNG_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT) + 1;

  logic [TRNG_WORD_W-1:0] prev_word_q;
  logic                   prev_vld_q;
  logic [REP_W-1:0]       rep_cnt_q, rep_next;
  logic                   health_fail_q;
  logic                   cap_done;

  assign cap_done = (state_q == ST_CAPTURE) && (cap_cnt_q == CAP_LAST) && cfg_enable;

  // Run length of identical words including the one being captured now.
  always_comb begin
    rep_next = REP_W'(1);
    if (prev_vld_q && (trng_random == prev_word_q))
      rep_next = (rep_cnt_q >= REP_W'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + 1'b1;
  end

  assign health_trip = (rep_next >= REP_W'(REP_LIMIT));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      prev_vld_q    <= 1'b0;
      rep_cnt_q     <= '0;
      health_fail_q <= 1'b0;
    end else begin
      if (cap_done) begin
        prev_vld_q <= 1'b1;
        rep_cnt_q  <= rep_next;
      end
      if (fault_enter) health_fail_q <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (cap_done) prev_word_q <= trng_random;
  end

  assign health_fail = health_fail_q;
`else
  assign health_trip = 1'b0;
  assign health_fail = 1'b0;
`endif

  trng_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .push_i  (push_w),
    .data_i  (trng_random),
    .pop_i   (c0_ack || c1_ack),
    .flush_i (flush_all),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
